// File: rtl/risc_ex_pkg.sv
// Shared execute-stage types: FS opcode encodings, FSM states, ALU flag bundle.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package risc_ex_pkg;

  localparam logic [4:0] FS_PASS = 5'b00000;
  localparam logic [4:0] FS_ADD  = 5'b00010;
  localparam logic [4:0] FS_SUB  = 5'b00101;
  localparam logic [4:0] FS_JML  = 5'b00111;
  localparam logic [4:0] FS_AND  = 5'b01000;
  localparam logic [4:0] FS_OR   = 5'b01010;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_NOT  = 5'b01110;
  localparam logic [4:0] FS_LSL  = 5'b10000;
  localparam logic [4:0] FS_LSR  = 5'b10001;
  localparam logic [4:0] FS_MUL  = 5'b11000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } ex_state_t;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } ex_flags_t;

  function automatic logic is_shift(input logic [4:0] fs);
    return (fs == FS_LSL) || (fs == FS_LSR);
  endfunction

endpackage

// File: rtl/risc_ex_stage_pipe_if.sv
// DOF->EX op channel and EX->WB result bundle, both valid/ready.
// Latency: none (wiring only).
// Backpressure: in_ready from the stage, out_ready from WB.
interface risc_ex_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int DA_W = 5
);
  localparam int SHW = $clog2(XLEN);

  logic            in_valid;
  logic            in_ready;
  logic            in_rw;
  logic            in_ps;
  logic            in_mw;
  logic [DA_W-1:0] in_da;
  logic [1:0]      in_md;
  logic [1:0]      in_bs;
  logic [4:0]      in_fs;
  logic [SHW-1:0]  in_sh;
  logic [XLEN-1:0] in_bus_a;
  logic [XLEN-1:0] in_bus_b;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic            out_rw;
  logic            out_ps;
  logic            out_mw;
  logic [DA_W-1:0] out_da;
  logic [1:0]      out_md;
  logic [1:0]      out_bs;
  logic [XLEN-1:0] out_f;
  logic            out_c;
  logic            out_v;
  logic            out_n;
  logic            out_z;
  logic            out_nxv;
  logic [XLEN-1:0] out_bra;
  logic [XLEN-1:0] out_raa;
  logic [XLEN-1:0] out_mem_addr;
  logic [XLEN-1:0] out_mem_din;
  logic [XLEN-1:0] out_f_hi;

  // Environment side: issues ops, consumes bundles.
  modport master (
    output in_valid, in_rw, in_ps, in_mw, in_da, in_md, in_bs, in_fs, in_sh,
           in_bus_a, in_bus_b, in_pc, out_ready,
    input  in_ready, out_valid, out_rw, out_ps, out_mw, out_da, out_md, out_bs,
           out_f, out_c, out_v, out_n, out_z, out_nxv, out_bra, out_raa,
           out_mem_addr, out_mem_din, out_f_hi
  );

  // Execute stage side.
  modport slave (
    input  in_valid, in_rw, in_ps, in_mw, in_da, in_md, in_bs, in_fs, in_sh,
           in_bus_a, in_bus_b, in_pc, out_ready,
    output in_ready, out_valid, out_rw, out_ps, out_mw, out_da, out_md, out_bs,
           out_f, out_c, out_v, out_n, out_z, out_nxv, out_bra, out_raa,
           out_mem_addr, out_mem_din, out_f_hi
  );

endinterface

// File: rtl/risc_ex_alu.sv
// Single-cycle ALU: PASS/ADD/SUB/logic/NOT/LSL/LSR/JML plus C/V/N/Z flags.
// Latency: 0 (pure combinational).
// Backpressure: none; caller registers the result.
module risc_ex_alu
  import risc_ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [4:0]      fs,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  input  logic [SHW-1:0]  sh,
  output logic [XLEN-1:0] f,
  output ex_flags_t       flags
);

  logic [XLEN:0] sum;

  // Decode FS, then derive N/Z from the XLEN-bit result; SUB is A + ~B + 1 so carry-out is NOT borrow.
  always_comb begin
    sum   = '0;
    f     = '0;
    flags = '0;
    case (fs)
      FS_PASS: f = a;
      FS_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        f       = sum[XLEN-1:0];
        flags.c = sum[XLEN];
        flags.v = (a[XLEN-1] == b[XLEN-1]) && (f[XLEN-1] != a[XLEN-1]);
      end
      FS_SUB: begin
        sum     = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
        f       = sum[XLEN-1:0];
        flags.c = sum[XLEN];
        flags.v = (a[XLEN-1] != b[XLEN-1]) && (f[XLEN-1] != a[XLEN-1]);
      end
      FS_AND:  f = a & b;
      FS_OR:   f = a | b;
      FS_XOR:  f = a ^ b;
      FS_NOT:  f = ~a;
      FS_LSL:  f = a << sh;
      FS_LSR:  f = a >> sh;
      FS_JML:  f = pc + XLEN'(1);
      default: f = '0;
    endcase
    flags.n = f[XLEN-1];
    flags.z = (f == '0) || (fs == FS_JML);
  end

endmodule

// File: rtl/risc_ex_stage_pipe.sv
// Registered RISC execute stage: ALU, iterative shifter (and shift-add multiply when EX_MUL_EN is defined).
// Latency: 1 cycle single-cycle ops; ceil(sh/SH_STEP)+1 for shifts; XLEN+1 for MUL.
// Backpressure: in_ready low while shifting/multiplying or while an unconsumed bundle is held.
module risc_ex_stage_pipe
  import risc_ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DA_W    = 5,
  parameter int SH_STEP = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  risc_ex_stage_pipe_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP_MAX = CW'(SH_STEP);

  ex_state_t       state;
  logic            out_valid_q;
  logic            rw_q, ps_q, mw_q;
  logic [DA_W-1:0] da_q;
  logic [1:0]      md_q, bs_q;
  logic [XLEN-1:0] f_q, bra_q, raa_q, din_q;
  ex_flags_t       fl_q;

  // Iterative datapath: acc is the shift operand (or multiplier/low product), cnt the remaining work.
  logic [XLEN-1:0] acc;
  logic            dir_r;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   step;
  logic [XLEN-1:0] acc_sh;

  logic [XLEN-1:0] alu_f;
  ex_flags_t       alu_fl;
  logic            accept;

  assign bus.in_ready = !reset && (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign step         = (cnt > STEP_MAX) ? STEP_MAX : cnt;
  assign acc_sh       = dir_r ? (acc >> step) : (acc << step);

  risc_ex_alu #(.XLEN(XLEN)) u_alu (
    .fs    (bus.in_fs),
    .a     (bus.in_bus_a),
    .b     (bus.in_bus_b),
    .pc    (bus.in_pc),
    .sh    (bus.in_sh),
    .f     (alu_f),
    .flags (alu_fl)
  );

`ifdef EX_MUL_EN
  // Multiplicand is the latched A operand, already held in raa_q for the bundle.
  logic [XLEN-1:0] hi, fhi_q, mul_lo;
  logic [XLEN:0]   mul_sum;
  assign mul_sum      = {1'b0, hi} + (acc[0] ? {1'b0, raa_q} : '0);
  assign mul_lo       = {mul_sum[0], acc[XLEN-1:1]};
  assign bus.out_f_hi = fhi_q;
`else
  assign bus.out_f_hi = '0;
`endif

  // Handshake, shift/multiply sequencing and the EX/WB output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      rw_q        <= 1'b0;
      ps_q        <= 1'b0;
      mw_q        <= 1'b0;
      da_q        <= '0;
      md_q        <= '0;
      bs_q        <= '0;
      f_q         <= '0;
      fl_q        <= '0;
      bra_q       <= '0;
      raa_q       <= '0;
      din_q       <= '0;
      acc         <= '0;
      dir_r       <= 1'b0;
      cnt         <= '0;
`ifdef EX_MUL_EN
      hi          <= '0;
      fhi_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
          if (accept) begin
            rw_q  <= bus.in_rw;
            ps_q  <= bus.in_ps;
            mw_q  <= bus.in_mw;
            da_q  <= bus.in_da;
            md_q  <= bus.in_md;
            bs_q  <= bus.in_bs;
            bra_q <= bus.in_pc + bus.in_bus_b;
            raa_q <= bus.in_bus_a;
            din_q <= bus.in_bus_b;
            acc   <= bus.in_bus_a;
            dir_r <= (bus.in_fs == FS_LSR);
            cnt   <= CW'(bus.in_sh);
`ifdef EX_MUL_EN
            fhi_q <= '0;
`endif
            if (is_shift(bus.in_fs) && (bus.in_sh != '0)) begin
              state <= SHIFT;
            end
`ifdef EX_MUL_EN
            else if (bus.in_fs == FS_MUL) begin
              state <= MUL;
              acc   <= bus.in_bus_b;
              hi    <= '0;
              cnt   <= CW'(XLEN);
            end
`endif
            else begin
              f_q         <= alu_f;
              fl_q        <= alu_fl;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= acc_sh;
          cnt <= cnt - step;
          if (cnt <= STEP_MAX) begin
            f_q         <= acc_sh;
            fl_q        <= '{c: 1'b0, v: 1'b0, n: acc_sh[XLEN-1], z: (acc_sh == '0)};
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
`ifdef EX_MUL_EN
        MUL: begin
          hi  <= mul_sum[XLEN:1];
          acc <= mul_lo;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            f_q         <= mul_lo;
            fhi_q       <= mul_sum[XLEN:1];
            fl_q        <= '{c: 1'b0, v: 1'b0, n: mul_lo[XLEN-1], z: (mul_lo == '0)};
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_rw       = rw_q;
  assign bus.out_ps       = ps_q;
  assign bus.out_mw       = mw_q;
  assign bus.out_da       = da_q;
  assign bus.out_md       = md_q;
  assign bus.out_bs       = bs_q;
  assign bus.out_f        = f_q;
  assign bus.out_c        = fl_q.c;
  assign bus.out_v        = fl_q.v;
  assign bus.out_n        = fl_q.n;
  assign bus.out_z        = fl_q.z;
  assign bus.out_nxv      = fl_q.n ^ fl_q.v;
  assign bus.out_bra      = bra_q;
  assign bus.out_raa      = raa_q;
  assign bus.out_mem_addr = raa_q;
  assign bus.out_mem_din  = din_q;

endmodule

// File: tb/tb_risc_ex_stage_pipe.sv
// Directed bench for the execute stage: vector table plus shift, hold, throughput and reset sequences.
// Latency: checks single-cycle, shift and multiply result timing.
// Backpressure: checks in_ready and bundle hold under out_ready=0.
module tb_risc_ex_stage_pipe;
  import risc_ex_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  risc_ex_stage_pipe_if #(.XLEN(32), .DA_W(5)) bus ();

  risc_ex_stage_pipe #(.XLEN(32), .DA_W(5), .SH_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every consumed bundle's result in order.
  logic [31:0] q[$];
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) q.push_back(bus.out_f);
  end

  typedef struct {
    logic [4:0]  fs;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  sh;
    logic [31:0] f;
    logic [3:0]  cvnz;
    logic [31:0] bra;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ctl_of(input int i);
    logic [7:0] id;
    id = 8'(i);
    return {id[0], id[1], id[2], 5'(id * 3), id[1:0] ^ 2'b10, id[3:2]};
  endfunction

  task automatic drive(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [4:0] sh, input int idx);
    logic [11:0] c;
    c = ctl_of(idx);
    bus.in_rw    = c[11];
    bus.in_ps    = c[10];
    bus.in_mw    = c[9];
    bus.in_da    = c[8:4];
    bus.in_md    = c[3:2];
    bus.in_bs    = c[1:0];
    bus.in_fs    = fs;
    bus.in_bus_a = a;
    bus.in_bus_b = b;
    bus.in_pc    = pc;
    bus.in_sh    = sh;
    bus.in_valid = 1'b1;
  endtask

  // Present an op and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [4:0] sh, input int idx, output int waited);
    logic rdy;
    logic done;
    drive(fs, a, b, pc, sh, idx);
    waited = 0;
    done   = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      else waited++;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  // Count cycles until out_valid, and how many of them had in_ready low.
  task automatic wait_valid(output int n, output int low);
    n   = 0;
    low = 0;
    while (!bus.out_valid && n < 100) begin
      if (!bus.in_ready) low++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout: got out_valid=0 expected 1 within 100 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, low, cntv, wsum, t;
    logic [4:0] fs12;

`ifdef EX_MUL_EN
    fs12 = 5'b11001;
`else
    fs12 = FS_MUL;
`endif
    //          fs       a             b             pc            sh     f             cvnz     bra
    vt[0]  = '{FS_ADD,  32'hFFFF_FFFF, 32'h1,        32'h100,      5'd0,  32'h0,        4'b1001, 32'h101};
    vt[1]  = '{FS_SUB,  32'h8000_0000, 32'h1,        32'h0,        5'd0,  32'h7FFF_FFFF,4'b1100, 32'h1};
    vt[2]  = '{FS_ADD,  32'h7FFF_FFFF, 32'h1,        32'hFFFF_FFFF,5'd0,  32'h8000_0000,4'b0110, 32'h0};
    vt[3]  = '{FS_SUB,  32'h5,         32'h7,        32'h20,       5'd0,  32'hFFFF_FFFE,4'b0010, 32'h27};
    vt[4]  = '{FS_SUB,  32'h3,         32'h3,        32'h0,        5'd0,  32'h0,        4'b1001, 32'h3};
    vt[5]  = '{FS_AND,  32'hF0F0_F0F0, 32'hFF00_FF00,32'h0,        5'd0,  32'hF000_F000,4'b0010, 32'hFF00_FF00};
    vt[6]  = '{FS_OR,   32'h0F0F_0000, 32'h0000_00F0,32'h4,        5'd0,  32'h0F0F_00F0,4'b0000, 32'hF4};
    vt[7]  = '{FS_XOR,  32'hAAAA_AAAA, 32'hFFFF_FFFF,32'h0,        5'd0,  32'h5555_5555,4'b0000, 32'hFFFF_FFFF};
    vt[8]  = '{FS_NOT,  32'h0,         32'h0,        32'h8,        5'd0,  32'hFFFF_FFFF,4'b0010, 32'h8};
    vt[9]  = '{FS_PASS, 32'h1234_5678, 32'h0,        32'h0,        5'd0,  32'h1234_5678,4'b0000, 32'h0};
    vt[10] = '{FS_JML,  32'h0,         32'h4,        32'h10,       5'd0,  32'h11,       4'b0001, 32'h14};
    vt[11] = '{FS_LSL,  32'h8000_0001, 32'h0,        32'h0,        5'd0,  32'h8000_0001,4'b0010, 32'h0};
    vt[12] = '{fs12,    32'h5,         32'h3,        32'h0,        5'd0,  32'h0,        4'b0001, 32'h3};
    vt[13] = '{5'b11111,32'h5,         32'h3,        32'h1,        5'd0,  32'h0,        4'b0001, 32'h4};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(FS_PASS, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_f", bus.out_f, 0);
    chk("reset_out_bra", bus.out_bra, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", bus.in_ready, 1);

    // Single-cycle vectors, back to back.
    for (int i = 0; i < NV; i++) begin
      send(vt[i].fs, vt[i].a, vt[i].b, vt[i].pc, vt[i].sh, i, w);
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d_f", i), bus.out_f, vt[i].f);
      chk($sformatf("v%0d_cvnz_nxv", i), {bus.out_c, bus.out_v, bus.out_n, bus.out_z, bus.out_nxv},
          {vt[i].cvnz, vt[i].cvnz[1] ^ vt[i].cvnz[2]});
      chk($sformatf("v%0d_bra", i), bus.out_bra, vt[i].bra);
      chk($sformatf("v%0d_ctl", i),
          {bus.out_rw, bus.out_ps, bus.out_mw, bus.out_da, bus.out_md, bus.out_bs}, ctl_of(i));
      chk($sformatf("v%0d_raa_din", i), {bus.out_raa, bus.out_mem_din}, {vt[i].a, vt[i].b});
      chk($sformatf("v%0d_mem_addr", i), bus.out_mem_addr, vt[i].a);
    end
    chk("f_hi_non_mul", bus.out_f_hi, 0);

    // LSL by 31 in steps of 4: eight SHIFT cycles with in_ready low.
    send(FS_LSL, 32'h1, 32'h0, 32'h0, 5'd31, 1, w);
    wait_valid(n, low);
    chk("lsl31_cycles", n, 8);
    chk("lsl31_ready_low", low, 8);
    chk("lsl31_f", bus.out_f, 32'h8000_0000);
    chk("lsl31_cvnz", {bus.out_c, bus.out_v, bus.out_n, bus.out_z}, 4'b0010);

    send(FS_LSR, 32'h8000_0000, 32'h0, 32'h0, 5'd5, 2, w);
    wait_valid(n, low);
    chk("lsr5_cycles", n, 2);
    chk("lsr5_f", bus.out_f, 32'h0400_0000);

    send(FS_LSR, 32'h8000_0000, 32'h0, 32'h0, 5'd4, 3, w);
    wait_valid(n, low);
    chk("lsr4_cycles", n, 1);
    chk("lsr4_f", bus.out_f, 32'h0800_0000);

`ifdef EX_MUL_EN
    send(FS_MUL, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd0, 4, w);
    wait_valid(n, low);
    chk("mul_cycles", n, 32);
    chk("mul_f", bus.out_f, 32'hFFFF_FFFE);
    chk("mul_f_hi", bus.out_f_hi, 32'h1);
    chk("mul_cvnz", {bus.out_c, bus.out_v, bus.out_n, bus.out_z}, 4'b0010);
`endif

    // Reset in the middle of a shift drops the op.
    @(posedge clk);
    #1;
    q.delete();
    send(FS_LSL, 32'h1, 32'h0, 32'h0, 5'd31, 5, w);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midshift_reset_valid", bus.out_valid, 0);
    chk("midshift_reset_f", bus.out_f, 0);
    chk("midshift_reset_in_ready", bus.in_ready, 1);
    cntv = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) cntv++;
    end
    chk("midshift_no_bundle", cntv, 0);
    chk("midshift_queue_empty", q.size(), 0);

    // Hold: out_ready low keeps the first ADD stable and blocks the next one.
    q.delete();
    bus.out_ready = 1'b0;
    send(FS_ADD, 32'h1, 32'h1, 32'h0, 5'd0, 6, w);
    drive(FS_ADD, 32'h2, 32'h2, 32'h0, 5'd0, 7);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_in_ready", k), bus.in_ready, 0);
      chk($sformatf("hold%0d_valid_f", k), {bus.out_valid, bus.out_f}, {1'b1, 32'h2});
      chk($sformatf("hold%0d_bra", k), bus.out_bra, 32'h1);
      @(posedge clk);
      #1;
    end
    chk("hold_none_consumed", q.size(), 0);
    bus.out_ready = 1'b1;
    send(FS_ADD, 32'h2, 32'h2, 32'h0, 5'd0, 7, w);
    send(FS_ADD, 32'h3, 32'h3, 32'h0, 5'd0, 8, w);
    t = 0;
    while (q.size() < 3 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("hold_count", q.size(), 3);
    chk("hold_order", {q[0], q[1]}, {32'h2, 32'h4});
    chk("hold_last", q[2], 32'h6);

    // Full throughput: four ADDs accepted on four consecutive edges.
    q.delete();
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      send(FS_ADD, 32'(16 * i), 32'(i), 32'h0, 5'd0, i, w);
      wsum += w;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("stream_no_stall", wsum, 0);
    chk("stream_count", q.size(), 4);
    chk("stream_order", {q[1], q[3]}, {32'd17, 32'd51});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
